sm510_rom_loader: RTL and testbench
===================================

// Module: sm510_rom_loader
// PURPOSE
//  Sits directly upstream of the sm510 core and serves as its program ROM.
//  Accepts a 16-bit little-endian download stream and splits each word into two byte writes into a 4096x8 RAM.
//  Answers the core's gated instruction fetch (rom_addr -> rom_data) with 1-clock latency.
//  Holds the core in reset until a complete image is loaded and has settled.
// PARAMETERS
//  ADDR_WIDTH    12    ROM byte address width; depth = 2**ADDR_WIDTH (4096)
//  SETTLE_CYCLES 16    clocks cpu_reset stays high after download ends (>=1)
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   synchronous, active-low reset
//  clk_en         in   1   core clock enable; fetch updates only when high
//  ioctl_download in   1   high for whole duration of an image download
//  ioctl_wr       in   1   1-clk strobe: ioctl_addr/ioctl_dout valid
//  ioctl_addr     in   13  byte address of low byte (bit0 ignored, treated 0)
//  ioctl_dout     in   16  [7:0] -> addr, [15:8] -> addr+1
//  ioctl_wait     out  1   high: loader busy, upstream must not strobe ioctl_wr
//  rom_addr       in   12  core fetch address
//  rom_data       out  8   fetched opcode byte
//  cpu_reset      out  1   active-high reset to sm510 core
//  load_done      out  1   high while in RUN
//  load_error     out  1   sticky: last download empty or had out-of-range write
//  bytes_loaded   out  13  bytes written by last/current download (saturating)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - state=EMPTY; outputs: rom_data=8'h00, ioctl_wait=0, cpu_reset=1, load_done=0, load_error=0, bytes_loaded=0.
//   - ROM array contents are NOT cleared.
//   - Reset wins over every other event in the same cycle.
//  States:
//   - EMPTY: entered from reset. Go to LOADING when ioctl_download=1.
//   - LOADING: entered from EMPTY, or from RUN/SETTLE on ioctl_download=1; entry clears bytes_loaded and load_error.
//     Exit when ioctl_download=0 and no high byte is pending -> SETTLE.
//   - SETTLE: counts SETTLE_CYCLES clocks, then -> RUN. ioctl_download=1 -> LOADING.
//   - RUN: cpu_reset=0, load_done=1. ioctl_download=1 -> LOADING.
//  Output registration:
//   - cpu_reset is registered. It is 1 in every state except RUN.
//   - It rises the clock after ioctl_download is sampled high in RUN.
//  Word accept (LOADING, ioctl_wr=1, ioctl_wait=0):
//   - cycle N: write dout[7:0] to addr; latch dout[15:8] and addr+1; ioctl_wait=1 from N+1.
//   - cycle N+1: write the latched high byte; ioctl_wait=0 from N+2.
//   - Sustained rate is 1 word per 2 clocks.
//  Handshake violations:
//   - ioctl_wr while ioctl_wait=1 is ignored (no write, no count).
//   - ioctl_wr outside LOADING is ignored.
//  Download end with a high byte pending:
//   - If ioctl_download falls while a high byte is pending, that byte is still written.
//   - SETTLE is entered one clock later.
//  Range check:
//   - Any byte whose address is >= 2**ADDR_WIDTH is dropped and sets load_error.
//   - The in-range half of a word is still written.
//  bytes_loaded:
//   - +1 per byte written; saturates at 4096.
//  load_error on empty download:
//   - Set on leaving LOADING when bytes_loaded==0.
//  Fetch:
//   - On a posedge with clk_en=1, rom_data <= rom[rom_addr]: data is valid the clock after the address is sampled.
//   - With clk_en=0, rom_data holds.
//   - Fetch runs in all states.
//  Port priority:
//   - The memory is single-port.
//   - A loader write in the same cycle as a fetch takes the port.
//   - rom_data holds in that cycle, which is harmless because the core is in reset while LOADING.
// TESTING
//  1. Reset, then download 2048 words 0x0000..0x07FF (dout = {addr[7:0]+1, addr[7:0]}).
//     -> bytes_loaded=4096, load_error=0.
//     -> cpu_reset falls SETTLE_CYCLES+1 clocks after ioctl_download falls.
//  2. After RUN, rom_addr=0x003 with clk_en pulse.
//     -> rom_data=0x03 the next clock; holds while clk_en=0.
//  3. Strobe ioctl_wr on consecutive clocks.
//     -> second strobe ignored (ioctl_wait=1); bytes_loaded increments by 2, not 4.
//  4. Write addr=0x0FFF... use addr 0x0FFE then 0x1000 with dout=0xBEEF.
//     -> 0x0FFE=EF, 0x0FFF=BE; write at 0x1000 dropped, load_error=1.
//  5. In RUN, raise ioctl_download.
//     -> cpu_reset=1 next clock, load_done=0, bytes_loaded=0.
//     Drop it with no writes -> load_error=1, still reaches RUN.
//  6. reset_n=0 mid-LOADING with high byte pending.
//     -> high byte not written, state EMPTY, ioctl_wait=0, cpu_reset=1.

Source files
------------

// File: rtl/sm510_rom_loader.sv
// sm510_rom_loader: program ROM for the sm510 core, filled from a 16-bit download stream
module sm510_rom_loader #(
  parameter int ADDR_WIDTH    = 12,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [12:0]           ioctl_addr,
  input  logic [15:0]           ioctl_dout,
  output logic                  ioctl_wait,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [12:0]           bytes_loaded
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {EMPTY, LOADING, SETTLE, RUN} state_t;
  state_t state, state_nx;
  logic [7:0] rom [DEPTH];
  logic hi_pend, accept, we, w_ok, entering;
  logic [12:0] hi_addr, waddr;
  logic [7:0] hi_byte, wdata;
  logic [CW-1:0] settle_cnt;
  assign ioctl_wait = hi_pend;
  assign load_done = state == RUN;
  always_comb begin
    accept = state == LOADING && ioctl_download && ioctl_wr && !hi_pend;
    waddr = hi_pend ? hi_addr : {ioctl_addr[12:1], 1'b0};
    wdata = hi_pend ? hi_byte : ioctl_dout[7:0];
    w_ok = 32'(waddr) < DEPTH;
    we = (hi_pend || accept) && w_ok;
    state_nx = (ioctl_download && state != LOADING) ? LOADING :
               (state == LOADING && !ioctl_download && !hi_pend) ? SETTLE :
               (state == SETTLE && settle_cnt == CW'(SETTLE_CYCLES - 1)) ? RUN : state;
    entering = state_nx == LOADING && state != LOADING;
  end
  // Loader writes own the single port; the fetch only reads when no write is in flight
  always_ff @(posedge clk)
    if (reset_n && we) rom[waddr[ADDR_WIDTH-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
      hi_pend <= 1'b0;
      settle_cnt <= '0;
      cpu_reset <= 1'b1;
      load_error <= 1'b0;
      bytes_loaded <= '0;
      rom_data <= 8'h00;
    end else begin
      state <= state_nx;
      hi_pend <= accept;
      if (accept) begin
        hi_addr <= {ioctl_addr[12:1], 1'b1};
        hi_byte <= ioctl_dout[15:8];
      end
      settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
      cpu_reset <= state_nx != RUN;
      bytes_loaded <= entering ? '0 :
                      (we && bytes_loaded != 13'(DEPTH)) ? bytes_loaded + 1'b1 : bytes_loaded;
      load_error <= entering ? 1'b0 :
                    (((hi_pend || accept) && !w_ok) ||
                     (state == LOADING && state_nx == SETTLE && bytes_loaded == '0)) ? 1'b1 : load_error;
      if (clk_en && !we) rom_data <= rom[rom_addr];
    end
  end
endmodule

// File: tb/tb_sm510_rom_loader.sv
// tb_sm510_rom_loader: randomized download/fetch checks against a byte-array ROM model
module tb_sm510_rom_loader;
  localparam int SETTLE = 16;
  logic clk = 0, reset_n = 0, clk_en = 0, ioctl_download = 0, ioctl_wr = 0;
  logic [12:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [11:0] rom_addr = '0;
  logic ioctl_wait, cpu_reset, load_done, load_error;
  logic [7:0] rom_data;
  logic [12:0] bytes_loaded;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mrom [4096];
  int mcnt = 0;
  bit merr = 0, mpend = 0;
  logic [12:0] mhi_a;
  logic [7:0] mhi_d;

  sm510_rom_loader dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [12:0] a, input logic [7:0] d);
    if (a < 13'h1000) begin
      mrom[a[11:0]] = d;
      mcnt = mcnt < 4096 ? mcnt + 1 : 4096;
    end else merr = 1;
  endtask

  task automatic step(input bit wr, input logic [12:0] a, input logic [15:0] d);
    bit acc;
    acc = wr && !mpend;
    if (mpend) put(mhi_a, mhi_d);
    if (acc) begin
      put({a[12:1], 1'b0}, d[7:0]);
      mhi_a = {a[12:1], 1'b1};
      mhi_d = d[15:8];
    end
    mpend = acc;
    ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 0;
    chk("ioctl_wait", ioctl_wait, mpend);
    chk("bytes_loaded", bytes_loaded, mcnt);
    chk("load_error", load_error, merr);
  endtask

  task automatic start_dl();
    ioctl_download = 1;
    tick();
    mcnt = 0; merr = 0; mpend = 0;
    chk("start cpu_reset", cpu_reset, 1);
    chk("start load_done", load_done, 0);
    chk("start bytes", bytes_loaded, 0);
    chk("start error", load_error, 0);
  endtask

  task automatic end_dl();
    int n;
    bit p;
    p = mpend;
    if (mpend) put(mhi_a, mhi_d);
    mpend = 0;
    if (mcnt == 0) merr = 1;
    ioctl_download = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_reset && n < 200);
    chk("settle_len", n, SETTLE + 1 + p);
    chk("run load_done", load_done, 1);
    chk("run error", load_error, merr);
    chk("run bytes", bytes_loaded, mcnt);
  endtask

  task automatic fetch(input logic [11:0] a);
    rom_addr = a; clk_en = 1;
    tick();
    clk_en = 0;
    chk("fetch", rom_data, mrom[a]);
  endtask

  initial begin
    logic [12:0] a;
    logic [7:0] lo;
    repeat (2) tick();
    chk("rst cpu_reset", cpu_reset, 1);
    chk("rst load_done", load_done, 0);
    chk("rst wait", ioctl_wait, 0);
    chk("rst rom_data", rom_data, 0);
    chk("rst bytes", bytes_loaded, 0);
    chk("rst error", load_error, 0);
    reset_n = 1;
    tick();
    chk("empty cpu_reset", cpu_reset, 1);
    // full image, then one extra word to exercise count saturation
    start_dl();
    for (int w = 0; w < 2048; w++) begin
      a = 13'(2 * w);
      lo = a[7:0];
      step(1, a, {lo + 8'd1, lo});
      step(0, 0, 0);
    end
    step(1, 13'h0000, 16'h0100);
    step(0, 0, 0);
    chk("saturated", bytes_loaded, 4096);
    end_dl();
    fetch(12'h003);
    chk("fetch 3", rom_data, 8'h03);
    rom_addr = 12'h005;
    repeat (2) tick();
    chk("fetch hold", rom_data, 8'h03);
    // back-to-back strobes: second one ignored
    start_dl();
    step(1, 13'h0100, 16'($urandom));
    step(1, 13'h0200, 16'($urandom));
    step(0, 0, 0);
    chk("b2b bytes", bytes_loaded, 2);
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 7) == 0 ? 13'h1000 | 13'($urandom) : 13'($urandom & 32'hFFF);
      step(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    step(0, 0, 0);
    step(1, 13'h0FFE, 16'hBEEF);
    step(0, 0, 0);
    step(1, 13'h1000, 16'hBEEF);
    end_dl();
    chk("range error", load_error, 1);
    fetch(12'hFFE);
    chk("ffe", rom_data, 8'hEF);
    fetch(12'hFFF);
    chk("fff", rom_data, 8'hBE);
    for (int i = 0; i < 24; i++) fetch(12'($urandom));
    // empty download from RUN
    start_dl();
    end_dl();
    chk("empty error", load_error, 1);
    // reset with a high byte pending
    start_dl();
    ioctl_wr = 1; ioctl_addr = 13'h0010; ioctl_dout = 16'h5AA5;
    tick();
    ioctl_wr = 0;
    mrom[12'h010] = 8'hA5;
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("mid rst wait", ioctl_wait, 0);
    chk("mid rst cpu_reset", cpu_reset, 1);
    chk("mid rst load_done", load_done, 0);
    chk("mid rst bytes", bytes_loaded, 0);
    chk("mid rst rom_data", rom_data, 0);
    start_dl();
    end_dl();
    fetch(12'h010);
    fetch(12'h011);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
